// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lsu_pkg
// Description : Shared definitions for the RV32I load/store unit:
//               funct3 encodings, DMEM data_type code, FSM state type,
//               DMEM base address and the request legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // RV32I funct3 encodings (loads use all five, stores use B/H/W)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // DMEM is always driven as a full-word access
   localparam logic [2:0] DT_WORD = 3'b010;

   // Base of the DMEM window (informational; addresses pass through unchanged)
   localparam logic [31:0] DMEM_BASE = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RSP  = 2'd3
   } state_t;

   // 1 when the request is misaligned or uses an illegal funct3
   function automatic logic req_error(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
      logic err;
      err = 1'b0;
      case (funct3)
         F3_B:    err = 1'b0;
         F3_H:    err = addr_lo[0];
         F3_W:    err = |addr_lo;
         F3_BU:   err = we;                 // no unsigned stores
         F3_HU:   err = we | addr_lo[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane logic. Extracts and sign/zero-extends
//               load data from a DMEM word, and merges sub-word store data
//               into a DMEM word for read-modify-write.
// Ports       : addr_lo   - byte offset within the word
//               funct3    - RV32I access type
//               rd_word   - word read from DMEM
//               st_data   - store data from the request
//               load_data - extended load result
//               st_word   - full word to write back
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] rd_word,
   input  logic [31:0] st_data,
   output logic [31:0] load_data,
   output logic [31:0] st_word
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = 8'h00;
      case (addr_lo)
         2'd0: byte_v = rd_word[7:0];
         2'd1: byte_v = rd_word[15:8];
         2'd2: byte_v = rd_word[23:16];
         2'd3: byte_v = rd_word[31:24];
         default: byte_v = 8'h00;
      endcase
      half_v = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

      load_data = rd_word;
      case (funct3)
         F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
         F3_BU:   load_data = {24'h0, byte_v};
         F3_H:    load_data = {{16{half_v[15]}}, half_v};
         F3_HU:   load_data = {16'h0, half_v};
         default: load_data = rd_word;
      endcase

      // Only the addressed lanes are replaced; the rest keep the read value
      st_word = rd_word;
      case (funct3)
         F3_B:    st_word[{addr_lo, 3'b000} +: 8]     = st_data[7:0];
         F3_H:    st_word[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
         default: st_word = st_data;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master
// Description : RV32I load/store initiator for a word-wide DMEM port. Accepts
//               one request, performs sub-word extract/extend or
//               read-modify-write, and returns a single held response.
// Ports       : clk, rst_n                    - clock, sync active-low reset
//               req_valid/req_ready/req_*     - request from execute stage
//               rsp_valid/rsp_ready/rsp_*     - response to consumer
//               memread/memwrite/addr/wr_data/
//               data_type/out_data            - DMEM port (word aligned)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32     // RV32I: only 32 is supported
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              memread,
   output logic              memwrite,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [2:0]        data_type,
   input  logic [DATA_W-1:0] out_data
);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [DATA_W-1:0] wr_word_q;   // store data, later replaced by merged word
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] st_word;

   lsu_lane_align u_lane_align (
      .addr_lo   (addr_q[1:0]),
      .funct3    (funct3_q),
      .rd_word   (out_data),
      .st_data   (wr_word_q),
      .load_data (load_data),
      .st_word   (st_word)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         funct3_q  <= 3'b000;
         wr_word_q <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q    <= req_addr;
                  we_q      <= req_we;
                  funct3_q  <= req_funct3;
                  wr_word_q <= req_we ? req_wdata : '0;
                  rdata_q   <= '0;
                  if (req_error(req_we, req_funct3, req_addr[1:0])) begin
                     err_q <= 1'b1;
                     state <= ST_RSP;
                  end else begin
                     err_q <= 1'b0;
                     // Full-word stores skip the read; SB/SH need the old word
                     state <= (req_we && req_funct3 == F3_W) ? ST_WR : ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (we_q) begin
                  wr_word_q <= st_word;
                  state     <= ST_WR;
               end else begin
                  rdata_q <= load_data;
                  state   <= ST_RSP;
               end
            end
            ST_WR: begin
               rdata_q <= '0;
               state   <= ST_RSP;
            end
            ST_RSP: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Strobes depend only on the state register, never on req_* inputs
   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RSP);
   assign memread   = (state == ST_RD);
   assign memwrite  = (state == ST_WR);
   assign addr      = {addr_q[ADDR_W-1:2], 2'b00};
   assign wr_data   = wr_word_q;
   assign data_type = DT_WORD;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
`default_nettype wire
